// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port data memory.
// Define DMEM_ARB_FIXED_PRIO_EN to make port 0 always win ties (fixed priority).
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_wea,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              err
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_d;
    logic              cur_id;
    logic              cur_we;
    logic              cur_oor;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_served;
`endif

    logic              load_c;
    logic              win_id_c;
    logic              win_we_c;
    logic              win_oor_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [DATA_W-1:0] win_wdata_c;

    // Winner selection and next-state logic
    always_comb begin
        state_d     = state;
        load_c      = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        win_id_c    = req1 & ~req0;
`else
        win_id_c    = req1 & (~req0 | ~last_served);
`endif
        win_we_c    = win_id_c ? we1    : we0;
        win_addr_c  = win_id_c ? addr1  : addr0;
        win_wdata_c = win_id_c ? wdata1 : wdata0;
        win_oor_c   = (win_addr_c >= ADDR_W'(DEPTH));
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    load_c  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_id   <= 1'b0;
            cur_we   <= 1'b0;
            cur_oor  <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_served <= 1'b1;
`endif
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wea  <= 1'b0;
            err      <= 1'b0;
        end else begin
            state   <= state_d;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_wea <= 1'b0;
            err     <= 1'b0;
            if (load_c) begin
                mem_addr <= win_addr_c;
                mem_din  <= win_wdata_c;
                mem_wea  <= win_we_c & ~win_oor_c;
                cur_id   <= win_id_c;
                cur_we   <= win_we_c;
                cur_oor  <= win_oor_c;
                gnt0     <= ~win_id_c;
                gnt1     <= win_id_c;
                err      <= win_oor_c;
            end
            if (state == ACCESS) begin
`ifndef DMEM_ARB_FIXED_PRIO_EN
                last_served <= cur_id;
`endif
                // Out-of-range reads return zero rather than whatever the memory drives
                if (!cur_we) begin
                    if (cur_id) begin
                        rdata1  <= cur_oor ? '0 : mem_dout;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= cur_oor ? '0 : mem_dout;
                        rvalid0 <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic        gnt0, rvalid0, gnt1, rvalid1, mem_wea, err;
    logic [15:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];
    bit          ls_model = 1'b1;
    int          wea_viol = 0;
    logic        prev_wea = 1'b0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wea(mem_wea),
        .mem_dout(mem_dout), .err(err)
    );

    always #5 clk = ~clk;

    // 64-word memory with combinational read; also watches for back-to-back wea
    assign mem_dout = mem[mem_addr[5:0]];
    always @(posedge clk) begin
        if (mem_wea) mem[mem_addr[5:0]] <= mem_din;
        if (prev_wea && mem_wea) wea_viol++;
        prev_wea <= mem_wea;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule: lone requester wins; a tie goes to the port not served last
    function automatic int winner(bit r0, bit r1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return r0 ? 0 : 1;
`else
        if (r0 && r1) return ls_model ? 0 : 1;
        return r0 ? 0 : 1;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_wea, err} !== 6'b0 || mem_addr !== 16'h0 ||
            mem_din !== 16'h0 || rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: flags=%b addr=%h din=%h rd0=%h rd1=%h required all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_wea, err}, mem_addr, mem_din, rdata0, rdata1);
        end
        rst = 1'b0;
        ls_model = 1'b1;
        step();
        checks++;
        if ({gnt0, gnt1, mem_wea, err} !== 4'b0) begin
            errors++;
            $display("FAIL idle_no_req: flags=%b required 0000", {gnt0, gnt1, mem_wea, err});
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < 64; i++) begin
            req0 = 1'b1; we0 = 1'b1; addr0 = 16'(i);
            wdata0 = (16'(i) * 16'h0101) ^ 16'h5A5A;
            step();
            checks++;
            if ({gnt0, gnt1, mem_wea, err} !== 4'b1010 || mem_addr !== addr0) begin
                errors++;
                $display("FAIL init_write[%0d]: flags=%b addr=%h required 1010 addr=%h",
                         i, {gnt0, gnt1, mem_wea, err}, mem_addr, addr0);
            end
            ref_mem[i] = wdata0;
            ls_model = 1'b0;
            req0 = 1'b0;
            step();
        end
    endtask

    task automatic test_write_read();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd5; wdata0 = 16'hBEEF;
        step();
        checks++;
        if ({gnt0, gnt1, mem_wea, err} !== 4'b1010 || mem_addr !== 16'd5 || mem_din !== 16'hBEEF) begin
            errors++;
            $display("FAIL wr_access: flags=%b addr=%h din=%h required 1010 0005 beef",
                     {gnt0, gnt1, mem_wea, err}, mem_addr, mem_din);
        end
        req0 = 1'b0;
        ref_mem[5] = 16'hBEEF;
        ls_model = 1'b0;
        step();
        checks++;
        if ({gnt0, mem_wea, rvalid0} !== 3'b000) begin
            errors++;
            $display("FAIL wr_after: gnt0/wea/rvalid0=%b required 000", {gnt0, mem_wea, rvalid0});
        end
        req0 = 1'b1; we0 = 1'b0;
        step();
        checks++;
        if ({gnt0, mem_wea, rvalid0} !== 3'b100) begin
            errors++;
            $display("FAIL rd_access: gnt0/wea/rvalid0=%b required 100", {gnt0, mem_wea, rvalid0});
        end
        req0 = 1'b0;
        step();
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_data: rvalid0=%b rdata0=%h required 1 beef", rvalid0, rdata0);
        end
    endtask

    task automatic test_contention();
        int pend;
        pend = 0;
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
        step();
        rst = 1'b0;
        ls_model = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k % 2 == 0) begin
                pend = winner(1'b1, 1'b1);
                checks++;
                if ({gnt0, gnt1} !== {pend == 0, pend == 1}) begin
                    errors++;
                    $display("FAIL contention_gnt[%0d]: gnt0/gnt1=%b required port %0d", k, {gnt0, gnt1}, pend);
                end
                ls_model = (pend == 1);
            end else begin
                checks++;
                if ({gnt0, gnt1} !== 2'b00 || {rvalid0, rvalid1} !== {pend == 0, pend == 1} ||
                    (pend == 0 && rdata0 !== ref_mem[1]) || (pend == 1 && rdata1 !== ref_mem[2])) begin
                    errors++;
                    $display("FAIL contention_rd[%0d]: gnt=%b rv=%b rd0=%h rd1=%h required port %0d data %h/%h",
                             k, {gnt0, gnt1}, {rvalid0, rvalid1}, rdata0, rdata1, pend, ref_mem[1], ref_mem[2]);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        step();
    endtask

    task automatic test_out_of_range();
        logic [15:0] word0;
        word0 = mem[0];
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd64; wdata1 = 16'h1234;
        step();
        checks++;
        if ({gnt0, gnt1, mem_wea, err} !== 4'b0101) begin
            errors++;
            $display("FAIL oor_write: flags=%b required 0101", {gnt0, gnt1, mem_wea, err});
        end
        req1 = 1'b0;
        ls_model = 1'b1;
        step();
        checks++;
        if ({err, mem_wea, rvalid1} !== 3'b000) begin
            errors++;
            $display("FAIL oor_write_after: err/wea/rvalid1=%b required 000", {err, mem_wea, rvalid1});
        end
        req1 = 1'b1; we1 = 1'b0;
        step();
        checks++;
        if ({gnt0, gnt1, mem_wea, err} !== 4'b0101) begin
            errors++;
            $display("FAIL oor_read: flags=%b required 0101", {gnt0, gnt1, mem_wea, err});
        end
        req1 = 1'b0;
        step();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== 16'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL oor_rdata: rvalid1=%b rdata1=%h err=%b required 1 0000 0", rvalid1, rdata1, err);
        end
        checks++;
        if (mem[0] !== word0 || mem[0] !== ref_mem[0]) begin
            errors++;
            $display("FAIL oor_word0: mem[0]=%h required %h", mem[0], ref_mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        int          w;
        logic [2:0]  wea_seq;
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'd3; wdata0 = 16'h3333;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd4; wdata1 = 16'h4444;
        w = winner(1'b1, 1'b1);
        step();
        wea_seq[2] = mem_wea;
        checks++;
        if ({gnt0, gnt1} !== {w == 0, w == 1} || mem_addr !== (w == 0 ? 16'd3 : 16'd4)) begin
            errors++;
            $display("FAIL b2b_first: gnt=%b addr=%h required port %0d", {gnt0, gnt1}, mem_addr, w);
        end
        if (w == 0) req0 = 1'b0; else req1 = 1'b0;
        ls_model = (w == 1);
        step();
        wea_seq[1] = mem_wea;
        step();
        wea_seq[0] = mem_wea;
        checks++;
        if ({gnt0, gnt1} !== {w == 1, w == 0}) begin
            errors++;
            $display("FAIL b2b_second: gnt=%b required port %0d", {gnt0, gnt1}, 1 - w);
        end
        req0 = 1'b0; req1 = 1'b0;
        ls_model = (w == 0);
        checks++;
        if (wea_seq !== 3'b101) begin
            errors++;
            $display("FAIL b2b_wea_seq: wea=%b required 101", wea_seq);
        end
        ref_mem[3] = 16'h3333; ref_mem[4] = 16'h4444;
        step();
        for (int a = 3; a <= 4; a++) begin
            req0 = 1'b1; we0 = 1'b0; addr0 = 16'(a);
            step();
            req0 = 1'b0;
            ls_model = 1'b0;
            step();
            checks++;
            if (rvalid0 !== 1'b1 || rdata0 !== ref_mem[a]) begin
                errors++;
                $display("FAIL b2b_readback[%0d]: rvalid0=%b rdata0=%h required 1 %h", a, rvalid0, rdata0, ref_mem[a]);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
        step();
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: gnt0=%b required 1", gnt0);
        end
        rst = 1'b1; req0 = 1'b0;
        step();
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_wea, err} !== 6'b0 || rdata0 !== 16'h0 || mem_addr !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: flags=%b rd0=%h addr=%h required all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_wea, err}, rdata0, mem_addr);
        end
        rst = 1'b0;
        ls_model = 1'b1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd4;
        step();
        checks++;
        if ({gnt0, gnt1, rvalid0} !== 3'b010) begin
            errors++;
            $display("FAIL rstmid_next_gnt: gnt0/gnt1/rvalid0=%b required 010", {gnt0, gnt1, rvalid0});
        end
        req1 = 1'b0;
        step();
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== ref_mem[4] || rvalid0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_rdata: rvalid1=%b rdata1=%h rvalid0=%b required 1 %h 0",
                     rvalid1, rdata1, rvalid0, ref_mem[4]);
        end
    endtask

    task automatic test_random();
        bit          pend [2];
        bit          pwe  [2];
        logic [15:0] pa   [2];
        logic [15:0] pd   [2];
        int          w;
        bit          oor;
        logic [15:0] exp_rd;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && $urandom_range(0, 2) != 0) begin
                    pend[q] = 1'b1;
                    pwe[q]  = 1'($urandom_range(0, 1));
                    pa[q]   = 16'($urandom_range(0, 71));
                    pd[q]   = 16'($urandom);
                end
            end
            req0 = pend[0]; we0 = pwe[0]; addr0 = pa[0]; wdata0 = pd[0];
            req1 = pend[1]; we1 = pwe[1]; addr1 = pa[1]; wdata1 = pd[1];
            if (!pend[0] && !pend[1]) begin
                step();
                checks++;
                if ({gnt0, gnt1, mem_wea} !== 3'b000) begin
                    errors++;
                    $display("FAIL rand_idle[%0d]: gnt/wea=%b required 000", n, {gnt0, gnt1, mem_wea});
                end
                continue;
            end
            w   = winner(pend[0], pend[1]);
            oor = (pa[w] >= 16'd64);
            step();
            checks++;
            if ({gnt0, gnt1, mem_wea, err} !== {w == 0, w == 1, pwe[w] && !oor, oor} || mem_addr !== pa[w] ||
                (pwe[w] && mem_din !== pd[w])) begin
                errors++;
                $display("FAIL rand_access[%0d]: flags=%b addr=%h din=%h required %b %h %h", n,
                         {gnt0, gnt1, mem_wea, err}, mem_addr, mem_din,
                         {w == 0, w == 1, pwe[w] && !oor, oor}, pa[w], pd[w]);
            end
            pend[w] = 1'b0;
            if (w == 0) req0 = 1'b0; else req1 = 1'b0;
            ls_model = (w == 1);
            if (pwe[w] && !oor) ref_mem[pa[w][5:0]] = pd[w];
            exp_rd = oor ? 16'h0 : ref_mem[pa[w][5:0]];
            step();
            checks++;
            if ({rvalid0, rvalid1} !== {!pwe[w] && w == 0, !pwe[w] && w == 1} ||
                (!pwe[w] && (w == 0 ? rdata0 : rdata1) !== exp_rd)) begin
                errors++;
                $display("FAIL rand_resp[%0d]: rv=%b rd0=%h rd1=%h required port %0d we %0d data %h",
                         n, {rvalid0, rvalid1}, rdata0, rdata1, w, pwe[w], exp_rd);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_wea_protocol();
        checks++;
        if (wea_viol !== 0) begin
            errors++;
            $display("FAIL wea_consecutive: %0d back-to-back wea cycles seen, required 0", wea_viol);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        test_wea_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
